// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states, cause codes and the
// little-endian byte-lane selector used when loading the handler address.
package exc_pkg;

  localparam int CAUSE_W = 2;

  localparam logic [CAUSE_W-1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_OVFL   = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_DIV0   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    READ,
    LOAD,
    DONE
  } exc_state_e;

  // Lane 0 is the least significant byte of the memory word.
  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Bus between the main datapath and the exception sequencer. The optional ExcCount output
// exists only when EXC_COUNT_EN is defined.
interface exception_sequencer_if;
  import exc_pkg::*;

  logic               exc_opcode;
  logic               exc_overflow;
  logic               exc_div_zero;
  logic [31:0]        pc_in;
  logic [31:0]        mem_data;

  logic               busy;
  logic               exc_mem_sel;
  logic [31:0]        exc_addr;
  logic               mem_read;
  logic               epc_write;
  logic [31:0]        epc_value;
  logic               cause_write;
  logic [CAUSE_W-1:0] cause;
  logic               pc_write;
  logic [31:0]        pc_value;
  logic               done;
`ifdef EXC_COUNT_EN
  logic [7:0]         exc_count;
`endif

  modport master (
`ifdef EXC_COUNT_EN
    input  exc_count,
`endif
    output exc_opcode, exc_overflow, exc_div_zero, pc_in, mem_data,
    input  busy, exc_mem_sel, exc_addr, mem_read, epc_write, epc_value,
    input  cause_write, cause, pc_write, pc_value, done
  );

  modport slave (
`ifdef EXC_COUNT_EN
    output exc_count,
`endif
    input  exc_opcode, exc_overflow, exc_div_zero, pc_in, mem_data,
    output busy, exc_mem_sel, exc_addr, mem_read, epc_write, epc_value,
    output cause_write, cause, pc_write, pc_value, done
  );

endinterface

// File: rtl/exc_priority_enc.sv
// Three-source exception priority encoder: divide-by-zero wins over overflow, which wins
// over invalid opcode.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic               exc_opcode,
  input  logic               exc_overflow,
  input  logic               exc_div_zero,
  output logic               valid,
  output logic [CAUSE_W-1:0] cause
);

  always_comb begin
    valid = exc_opcode | exc_overflow | exc_div_zero;
    cause = CAUSE_OPCODE;
    if (exc_div_zero) begin
      cause = CAUSE_DIV0;
    end else if (exc_overflow) begin
      cause = CAUSE_OVFL;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception sequencer: saves EPC/Cause, fetches the handler byte from the
// exception vector and loads it into PC. Define EXC_COUNT_EN to add the ExcCount output.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'd253,
  parameter int          MEM_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  exception_sequencer_if.slave  bus
);

  localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);

  exc_state_e         state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic busy_q, busy_d;
  logic exc_mem_sel_q, exc_mem_sel_d;
  logic mem_read_q, mem_read_d;
  logic epc_write_q, epc_write_d;
  logic cause_write_q, cause_write_d;
  logic pc_write_q, pc_write_d;
  logic done_q, done_d;

  logic               enc_valid;
  logic [CAUSE_W-1:0] enc_cause;
  logic [31:0]        exc_addr;

  exc_priority_enc u_prio (
    .exc_opcode   (bus.exc_opcode),
    .exc_overflow (bus.exc_overflow),
    .exc_div_zero (bus.exc_div_zero),
    .valid        (enc_valid),
    .cause        (enc_cause)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = SAVE;
          cause_d = enc_cause;
          epc_d   = bus.pc_in - 32'd4;
        end
      end
      SAVE: begin
        state_d = READ;
        cnt_d   = '0;
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_comb begin
    busy_d        = (state_d != IDLE);
    epc_write_d   = (state_d == SAVE);
    cause_write_d = (state_d == SAVE);
    mem_read_d    = (state_d == READ);
    exc_mem_sel_d = (state_d == READ) || (state_d == LOAD);
    pc_write_d    = (state_d == LOAD);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cause_q       <= CAUSE_OPCODE;
      epc_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      exc_mem_sel_q <= 1'b0;
      mem_read_q    <= 1'b0;
      epc_write_q   <= 1'b0;
      cause_write_q <= 1'b0;
      pc_write_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      exc_mem_sel_q <= exc_mem_sel_d;
      mem_read_q    <= mem_read_d;
      epc_write_q   <= epc_write_d;
      cause_write_q <= cause_write_d;
      pc_write_q    <= pc_write_d;
      done_q        <= done_d;
    end
  end

`ifdef EXC_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == IDLE) && (state_d == SAVE) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.exc_count = count_q;
`endif

  // Vector arithmetic wraps at 32 bits; the low two address bits pick the byte lane.
  assign exc_addr        = VECTOR_BASE + {{(32-CAUSE_W){1'b0}}, cause_q};
  assign bus.exc_addr    = exc_addr;
  assign bus.pc_value    = {24'b0, select_byte(bus.mem_data, exc_addr[1:0])};
  assign bus.epc_value   = epc_q;
  assign bus.cause       = cause_q;
  assign bus.busy        = busy_q;
  assign bus.exc_mem_sel = exc_mem_sel_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.epc_write   = epc_write_q;
  assign bus.cause_write = cause_write_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.done        = done_q;

endmodule
